// File: rtl/edge_bbox_stat_if.sv
// Binary edge-image stream from the Sobel stage: frame/line levels, pixel strobe and data.
interface edge_bbox_stat_if;
  logic       pre_img_vsync;
  logic       pre_img_hsync;
  logic       pre_img_valid;
  logic [7:0] pre_img_data;

  modport master (
    output pre_img_vsync,
    output pre_img_hsync,
    output pre_img_valid,
    output pre_img_data
  );

  modport slave (
    input pre_img_vsync,
    input pre_img_hsync,
    input pre_img_valid,
    input pre_img_data
  );
endinterface

// File: rtl/edge_bbox_stat.sv
// Per-frame edge-pixel count, bounding box and geometry check for a binary edge stream.
// Publishes one registered result set per frame with a single-cycle result_valid strobe.
module edge_bbox_stat #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned BORDER     = 1,
  parameter int unsigned EDGE_LEVEL = 255,
  parameter int unsigned CW         = 12,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  edge_bbox_stat_if.slave  pre_img,
  output logic [CW-1:0]    bbox_x_min,
  output logic [CW-1:0]    bbox_x_max,
  output logic [CW-1:0]    bbox_y_min,
  output logic [CW-1:0]    bbox_y_max,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             bbox_valid,
  output logic             frame_err,
  output logic             result_valid
);

  localparam logic [CW-1:0] HActive = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive = CW'(V_ACTIVE);
  localparam logic [CW-1:0] XLo     = CW'(BORDER);
  localparam logic [CW-1:0] XHi     = CW'(H_ACTIVE - BORDER);
  localparam logic [CW-1:0] YLo     = CW'(BORDER);
  localparam logic [CW-1:0] YHi     = CW'(V_ACTIVE - BORDER);
  localparam logic [7:0]    EdgeLvl = 8'(EDGE_LEVEL);
  localparam bit            NoBorder = (BORDER == 0);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e           state_q;
  logic             vsync_q, hsync_q;
  logic [CW-1:0]    x_cnt_q, y_cnt_q;
  logic [CW-1:0]    x_min_q, x_max_q, y_min_q, y_max_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic frame_start, frame_end, line_end;
  logic pix_take, is_edge, in_win, count_pix, y_bad;

  always_comb begin
    frame_start = pre_img.pre_img_vsync & ~vsync_q;
    frame_end   = ~pre_img.pre_img_vsync & vsync_q;
    line_end    = ~pre_img.pre_img_hsync & hsync_q;
    pix_take    = pre_img.pre_img_valid & pre_img.pre_img_vsync & pre_img.pre_img_hsync;
    is_edge     = pre_img.pre_img_data >= EdgeLvl;
    // With no border every pixel counts, even past the nominal line length.
    in_win      = NoBorder ||
                  ((x_cnt_q >= XLo) && (x_cnt_q < XHi) && (y_cnt_q >= YLo) && (y_cnt_q < YHi));
    count_pix   = pix_take & is_edge & in_win;
    y_bad       = (y_cnt_q != VActive);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b1;
      hsync_q      <= 1'b1;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      x_min_q      <= '1;
      x_max_q      <= '0;
      y_min_q      <= '1;
      y_max_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      bbox_x_min   <= '0;
      bbox_x_max   <= '0;
      bbox_y_min   <= '0;
      bbox_y_max   <= '0;
      edge_cnt     <= '0;
      bbox_valid   <= 1'b0;
      frame_err    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      vsync_q      <= pre_img.pre_img_vsync;
      hsync_q      <= pre_img.pre_img_hsync;
      result_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            state_q <= StActive;
          end
        end
        StActive: begin
          if (pix_take) begin
            if (count_pix) begin
              if (x_cnt_q < x_min_q) x_min_q <= x_cnt_q;
              if (x_cnt_q > x_max_q) x_max_q <= x_cnt_q;
              if (y_cnt_q < y_min_q) y_min_q <= y_cnt_q;
              if (y_cnt_q > y_max_q) y_max_q <= y_cnt_q;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            if (x_cnt_q != '1) x_cnt_q <= x_cnt_q + 1'b1;
          end
          // pix_take and line_end are exclusive (hsync high vs. falling), so no update clash.
          if (line_end && (x_cnt_q != '0)) begin
            if (x_cnt_q != HActive) err_q <= 1'b1;
            if (y_cnt_q != '1) y_cnt_q <= y_cnt_q + 1'b1;
            x_cnt_q <= '0;
          end
          if (frame_end) state_q <= StDone;
        end
        StDone: begin
          err_q        <= err_q | y_bad;
          frame_err    <= err_q | y_bad;
          edge_cnt     <= cnt_q;
          bbox_valid   <= (cnt_q != '0);
          bbox_x_min   <= (cnt_q != '0) ? x_min_q : '0;
          bbox_x_max   <= (cnt_q != '0) ? x_max_q : '0;
          bbox_y_min   <= (cnt_q != '0) ? y_min_q : '0;
          bbox_y_max   <= (cnt_q != '0) ? y_max_q : '0;
          result_valid <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_bbox_stat.sv
// Scoreboard bench: two instances (border 1 / wide counter, border 0 / 4-bit counter) share one
// stream; expected results are queued per frame and compared when result_valid fires.
module tb_edge_bbox_stat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  edge_bbox_stat_if sif ();

  logic [11:0] a_xmn, a_xmx, a_ymn, a_ymx, b_xmn, b_xmx, b_ymn, b_ymx;
  logic [23:0] a_cnt;
  logic [3:0]  b_cnt;
  logic        a_bv, a_err, a_rv, b_bv, b_err, b_rv;

  edge_bbox_stat #(
    .H_ACTIVE(8), .V_ACTIVE(6), .BORDER(1), .EDGE_LEVEL(255), .CW(12), .CNT_W(24)
  ) dut_a (
    .clk(clk), .rst(rst), .pre_img(sif),
    .bbox_x_min(a_xmn), .bbox_x_max(a_xmx), .bbox_y_min(a_ymn), .bbox_y_max(a_ymx),
    .edge_cnt(a_cnt), .bbox_valid(a_bv), .frame_err(a_err), .result_valid(a_rv)
  );

  edge_bbox_stat #(
    .H_ACTIVE(8), .V_ACTIVE(6), .BORDER(0), .EDGE_LEVEL(255), .CW(12), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .pre_img(sif),
    .bbox_x_min(b_xmn), .bbox_x_max(b_xmx), .bbox_y_min(b_ymn), .bbox_y_max(b_ymx),
    .edge_cnt(b_cnt), .bbox_valid(b_bv), .frame_err(b_err), .result_valid(b_rv)
  );

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt, bv, err, due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] img [0:7][0:7];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference result for one frame as driven: line y has 8 pixels, 7 if y == short_y.
  function automatic exp_t model(input int border, input int cnt_max, input int nlines,
                                 input int short_y);
    exp_t e;
    e.xmin = 4095; e.xmax = 0; e.ymin = 4095; e.ymax = 0; e.cnt = 0; e.due = 0;
    e.err = (nlines != 6) || (short_y >= 0 && short_y < nlines);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < ((y == short_y) ? 7 : 8); x++) begin
        if (img[y][x] == 8'd255 &&
            (border == 0 || (x >= border && x < 8 - border && y >= border && y < 6 - border)))
        begin
          if (e.cnt < cnt_max) e.cnt++;
          if (x < e.xmin) e.xmin = x;
          if (x > e.xmax) e.xmax = x;
          if (y < e.ymin) e.ymin = y;
          if (y > e.ymax) e.ymax = y;
        end
      end
    end
    e.bv = (e.cnt != 0);
    if (e.cnt == 0) begin
      e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
    end
    return e;
  endfunction

  task automatic cmp_res(input string p, input exp_t e, input logic [11:0] xmn, xmx, ymn, ymx,
                         input logic [23:0] c, input logic bv, input logic err);
    check({p, "_xmin"}, xmn, e.xmin);
    check({p, "_xmax"}, xmx, e.xmax);
    check({p, "_ymin"}, ymn, e.ymin);
    check({p, "_ymax"}, ymx, e.ymax);
    check({p, "_cnt"}, c, e.cnt);
    check({p, "_bvalid"}, bv, e.bv);
    check({p, "_ferr"}, err, e.err);
    check({p, "_latency_cyc"}, cyc, e.due);
  endtask

  always @(negedge clk) begin
    if (a_rv) begin
      if (qa.size() == 0) check("a_unexpected_result", 1, 0);
      else cmp_res("a", qa.pop_front(), a_xmn, a_xmx, a_ymn, a_ymx, a_cnt, a_bv, a_err);
    end
    if (b_rv) begin
      if (qb.size() == 0) check("b_unexpected_result", 1, 0);
      else cmp_res("b", qb.pop_front(), b_xmn, b_xmx, b_ymn, b_ymx, {20'd0, b_cnt}, b_bv, b_err);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_a_outs"}, {a_xmn, a_xmx, a_ymn, a_ymx, a_cnt[15:0]}, 64'd0);
    check({tag, "_a_flags"}, {a_cnt[23:16], a_bv, a_err, a_rv}, 0);
    check({tag, "_b_outs"}, {b_xmn, b_xmx, b_ymn, b_ymx, b_cnt}, 0);
    check({tag, "_b_flags"}, {b_bv, b_err, b_rv}, 0);
  endtask

  task automatic set_img(input int mode);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        case (mode)
          0: img[y][x] = (x == 0 || x == 7 || y == 0 || y == 5) ? 8'd255 : 8'd0;
          1: img[y][x] = 8'd255;
          default: img[y][x] = 8'd0;
        endcase
    if (mode != 1 && mode != 3) begin
      img[1][2] = 8'd255;
      img[3][5] = 8'd255;
      img[4][3] = 8'd255;
    end
  endtask

  // rst_line: -1 none, -2 reset held through frame start, >= 0 pulse before that line.
  task automatic drive_frame(input int nlines, input int short_y, input bit merge_end,
                             input bit extra_pix, input int rst_line);
    exp_t ea, eb;
    bit   expect_out;
    expect_out = (rst_line == -1);
    ea = model(1, 24'hFFFFFF, nlines, short_y);
    eb = model(0, 15, nlines, short_y);
    @(negedge clk);
    sif.pre_img_vsync = 1'b1;
    if (rst_line == -2) rst = 1'b1;
    @(negedge clk);
    if (rst_line == -2) begin
      rst = 1'b0;
      check_zero("rst_at_vsync");
    end
    for (int y = 0; y < nlines; y++) begin
      if (y == rst_line) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_mid_frame");
      end
      for (int x = 0; x < ((y == short_y) ? 7 : 8); x++) begin
        @(negedge clk);
        sif.pre_img_hsync = 1'b1;
        sif.pre_img_valid = 1'b1;
        sif.pre_img_data  = img[y][x];
      end
      if (merge_end && y == nlines - 1) break;
      @(negedge clk);
      sif.pre_img_hsync = 1'b0;
      sif.pre_img_valid = 1'b0;
      sif.pre_img_data  = 8'd0;
      @(negedge clk);
    end
    @(negedge clk);
    sif.pre_img_vsync = 1'b0;
    sif.pre_img_hsync = 1'b0;
    sif.pre_img_valid = extra_pix;
    sif.pre_img_data  = extra_pix ? 8'd255 : 8'd0;
    ea.due = cyc + 2;
    eb.due = cyc + 2;
    if (expect_out) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(negedge clk);
    sif.pre_img_valid = 1'b0;
    sif.pre_img_data  = 8'd0;
    repeat (8) @(negedge clk);
    check("result_drain", qa.size() + qb.size(), 0);
  endtask

  initial begin
    sif.pre_img_vsync = 1'b0;
    sif.pre_img_hsync = 1'b0;
    sif.pre_img_valid = 1'b0;
    sif.pre_img_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_img(0);
    drive_frame(6, -1, 1'b0, 1'b0, -1);  // basic box
    set_img(2);
    drive_frame(6, -1, 1'b0, 1'b0, -1);  // interior edges only
    set_img(0);
    for (int y = 0; y < 8; y++)
      for (int x = 1; x < 7; x++)
        if (y > 0 && y < 5) img[y][x] = 8'd0;
    drive_frame(6, -1, 1'b0, 1'b0, -1);  // empty interior
    set_img(0);
    drive_frame(6, 2, 1'b0, 1'b0, -1);   // short line
    drive_frame(5, -1, 1'b0, 1'b0, -1);  // too few lines
    drive_frame(6, -1, 1'b0, 1'b0, -1);  // recovers
    set_img(2);
    drive_frame(6, -1, 1'b1, 1'b1, -1);  // hsync/vsync fall together, stray pixel dropped
    set_img(0);
    drive_frame(6, -1, 1'b0, 1'b0, 3);   // reset mid-frame: no result
    drive_frame(6, -1, 1'b0, 1'b0, -1);
    drive_frame(6, -1, 1'b0, 1'b0, -2);  // reset released with vsync high: ignored
    set_img(1);
    drive_frame(6, -1, 1'b0, 1'b0, -1);  // all edges, saturates the 4-bit counter
    set_img(3);
    drive_frame(6, -1, 1'b1, 1'b0, -1);  // all zero

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
